dea_frame_loader: RTL

DEA_FRAME_LOADER -- requirements
Module: dea_frame_loader

---
 rtl/dea_frame_loader.sv | 117 +++++++++++
 1 files changed

// File: rtl/dea_frame_loader.sv
// Frames an ASCII byte stream into DEA key and message loads.
// Optional DEA_LOADER_CRLF_EN: discard 0x0D in key and message phases.
module dea_frame_loader #(
   parameter int MAX_KEY = 5,
   parameter int MAX_MSG = 1024
) (
   input  logic        dclk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        dea_reset,
   output logic        dea_kset,
   output logic [7:0]  dea_din,
   output logic        dea_stb,
   output logic [2:0]  key_len,
   output logic [10:0] msg_len,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE, CLR, KEY, MSG, DONE, ERR
   } state_t;

   localparam logic [2:0]  KMAX   = 3'(MAX_KEY);
   localparam logic [10:0] MLAST  = 11'(MAX_MSG - 1);

   state_t state, state_d;
   logic   accept, is_lf, is_cr;
   logic   stb_d, key_inc, msg_inc, clr_cnt;

   assign accept = in_valid & in_ready;
   assign is_lf  = (in_data == 8'h0A);
`ifdef DEA_LOADER_CRLF_EN
   assign is_cr  = (in_data == 8'h0D);
`else
   assign is_cr  = 1'b0;
`endif

   assign in_ready  = (state == KEY) || (state == MSG);
   assign dea_reset = (state == CLR);
   assign done      = (state == DONE);
   assign err       = (state == ERR);
   assign busy      = (state != IDLE) && (state != ERR);

   always_comb begin
      state_d = state;
      stb_d   = 1'b0;
      key_inc = 1'b0;
      msg_inc = 1'b0;
      clr_cnt = 1'b0;
      unique case (state)
         IDLE, ERR: begin
            if (start) begin
               state_d = CLR;
               clr_cnt = 1'b1;
            end
         end
         CLR: state_d = KEY;
         KEY: begin
            if (accept && !is_cr) begin
               if (is_lf) begin
                  state_d = (key_len == 3'd0) ? ERR : MSG;
               end else if (key_len == KMAX) begin
                  state_d = ERR;
               end else begin
                  stb_d   = 1'b1;
                  key_inc = 1'b1;
               end
            end
         end
         MSG: begin
            if (accept && !is_cr) begin
               if (is_lf) begin
                  state_d = DONE;
               end else begin
                  stb_d   = 1'b1;
                  msg_inc = 1'b1;
                  // last byte that fits closes the frame
                  if (msg_len == MLAST) state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge dclk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         dea_stb  <= 1'b0;
         dea_kset <= 1'b0;
         dea_din  <= 8'h00;
         key_len  <= 3'd0;
         msg_len  <= 11'd0;
      end else begin
         state   <= state_d;
         dea_stb <= stb_d;
         if (stb_d) begin
            dea_din  <= in_data;
            dea_kset <= (state == KEY);
         end
         if (clr_cnt) begin
            key_len <= 3'd0;
            msg_len <= 11'd0;
         end else begin
            if (key_inc) key_len <= key_len + 3'd1;
            if (msg_inc) msg_len <= msg_len + 11'd1;
         end
      end
   end

endmodule
